// File: rtl/zx_kbd_spi_rx.sv
// zx_kbd_spi_rx: SPI receiver for the 40-key ZX matrix (port #FE) and Kempston byte (port #1F).
// Optional feature macro KBD_JOY_EN: when defined, frames carry 8 joystick bits after the 40 key bits.
`timescale 1ns/1ps
module zx_kbd_spi_rx #(
    parameter int unsigned TIMEOUT_W = 22
) (
    input  logic       CLK_14MHZ,
    input  logic       CPU_RESET,
    input  logic       KBD_CLK,
    input  logic       KBD_DI,
    input  logic       KBD_CS,
    input  logic [7:0] A_HI,
    output logic [4:0] kd,
    output logic [7:0] joy,
    output logic       frame_ok,
    output logic       link_up
);

`ifdef KBD_JOY_EN
    localparam int unsigned FRAME_BITS = 48;
`else
    localparam int unsigned FRAME_BITS = 40;
`endif
    localparam int unsigned KEY_BITS  = 40;
    localparam int unsigned ROWS      = 8;
    localparam int unsigned COLS      = 5;
    localparam int unsigned CNT_W     = 6;
    localparam logic [CNT_W-1:0]     CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]     CNT_FRAME = CNT_W'(FRAME_BITS);
    localparam logic [TIMEOUT_W-1:0] WD_MAX    = '1;
    localparam logic [TIMEOUT_W-1:0] WD_LAST   = WD_MAX - TIMEOUT_W'(1);

    logic clk_s1, clk_s2, clk_s3;
    logic di_s1, di_s2;
    logic cs_s1, cs_s2, cs_s3;

    logic                  armed;
    logic [CNT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-1:0] shift_sr;
    logic                  commit_pend;
    logic [KEY_BITS-1:0]   matrix;
    logic [TIMEOUT_W-1:0]  wd_cnt;

    logic clk_rise, cs_rise, cs_fall;
    logic take_bit, frame_start, frame_end, wd_expire;

    // CS synchronizer resets low so the receiver only arms after a real idle-high CS
    always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
        if (!CPU_RESET) begin
            clk_s1 <= 1'b0;
            clk_s2 <= 1'b0;
            clk_s3 <= 1'b0;
            di_s1  <= 1'b0;
            di_s2  <= 1'b0;
            cs_s1  <= 1'b0;
            cs_s2  <= 1'b0;
            cs_s3  <= 1'b0;
        end else begin
            clk_s1 <= KBD_CLK;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            di_s1  <= KBD_DI;
            di_s2  <= di_s1;
            cs_s1  <= KBD_CS;
            cs_s2  <= cs_s1;
            cs_s3  <= cs_s2;
        end
    end

    assign clk_rise    = clk_s2 & ~clk_s3;
    assign cs_rise     = cs_s2 & ~cs_s3;
    assign cs_fall     = ~cs_s2 & cs_s3;
    assign take_bit    = armed & clk_rise & ~cs_s2 & ~commit_pend;
    assign frame_start = armed & cs_fall;
    assign frame_end   = armed & cs_rise & (bit_cnt == CNT_FRAME);
    assign wd_expire   = (wd_cnt >= WD_LAST);

    // Serial receive: newest bit enters at the top so arrival index n ends up at shift_sr[n]
    always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
        if (!CPU_RESET) begin
            armed       <= 1'b0;
            bit_cnt     <= '0;
            shift_sr    <= '0;
            commit_pend <= 1'b0;
        end else begin
            if (!armed && cs_s2) begin
                armed <= 1'b1;
            end
            if (frame_start) begin
                bit_cnt <= take_bit ? CNT_W'(1) : '0;
            end else if (take_bit && (bit_cnt != CNT_MAX)) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (take_bit) begin
                shift_sr <= {di_s2, shift_sr[FRAME_BITS-1:1]};
            end
            commit_pend <= frame_end;
        end
    end

    // Commit and link watchdog; a commit always overrides an expiry in the same cycle
    always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
        if (!CPU_RESET) begin
            matrix   <= '1;
            frame_ok <= 1'b0;
            link_up  <= 1'b0;
            wd_cnt   <= '0;
        end else begin
            frame_ok <= commit_pend;
            if (commit_pend) begin
                matrix  <= shift_sr[KEY_BITS-1:0];
                link_up <= 1'b1;
                wd_cnt  <= '0;
            end else begin
                if (wd_cnt != WD_MAX) begin
                    wd_cnt <= wd_cnt + TIMEOUT_W'(1);
                end
                if (wd_expire) begin
                    matrix  <= '1;
                    link_up <= 1'b0;
                end
            end
        end
    end

`ifdef KBD_JOY_EN
    logic [7:0] joy_rx;
    logic [7:0] joy_q;

    // Joystick byte arrives MSB first after the key bits
    for (genvar i = 0; i < 8; i++) begin : g_joy
        assign joy_rx[7-i] = shift_sr[KEY_BITS+i];
    end

    always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
        if (!CPU_RESET) begin
            joy_q <= 8'h00;
        end else if (commit_pend) begin
            joy_q <= joy_rx;
        end else if (wd_expire) begin
            joy_q <= 8'h00;
        end
    end

    assign joy = joy_q;
`else
    assign joy = 8'h00;
`endif

    // Half-row scan: a column reads 0 if any selected row has that key pressed
    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [ROWS-1:0] released;
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            assign released[r] = A_HI[r] | matrix[r*COLS+c];
        end
        assign kd[c] = &released;
    end

endmodule

// File: tb/tb_zx_kbd_spi_rx.sv
// Bench for zx_kbd_spi_rx: directed SPI frames against a frame-level model of the matrix,
// joystick byte, link state and watchdog, checked every cycle plus literal spot checks.
`timescale 1ns/1ps
module tb_zx_kbd_spi_rx;
`ifdef KBD_JOY_EN
    localparam int FB     = 48;
    localparam bit JOY_EN = 1'b1;
`else
    localparam int FB     = 40;
    localparam bit JOY_EN = 1'b0;
`endif
    localparam int TW = 8;
    localparam int WD = (1 << TW) - 1;

    logic       CLK_14MHZ = 1'b0;
    logic       CPU_RESET;
    logic       KBD_CLK, KBD_DI, KBD_CS;
    logic [7:0] A_HI;
    logic [4:0] kd;
    logic [7:0] joy;
    logic       frame_ok, link_up;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // frame-level model state
    logic [39:0] m_mat  = '1;
    logic [7:0]  m_joy  = 8'h00;
    logic        m_link = 1'b0;
    logic        m_fok  = 1'b0;
    logic [4:0]  kd_e;
    int          age = 0;
    bit          pend = 1'b0;
    int          pend_cyc = 0;
    logic [47:0] pend_bits = '0;
    bit          cs_high_seen = 1'b0;
    bit          arm_ok = 1'b0;
    int          nbits = 0;
    logic [47:0] rx = '0;
    logic [39:0] mat;

    zx_kbd_spi_rx #(.TIMEOUT_W(TW)) dut (
        .CLK_14MHZ(CLK_14MHZ),
        .CPU_RESET(CPU_RESET),
        .KBD_CLK  (KBD_CLK),
        .KBD_DI   (KBD_DI),
        .KBD_CS   (KBD_CS),
        .A_HI     (A_HI),
        .kd       (kd),
        .joy      (joy),
        .frame_ok (frame_ok),
        .link_up  (link_up)
    );

    always #35 CLK_14MHZ = ~CLK_14MHZ;
    always @(posedge CLK_14MHZ) cyc <= cyc + 1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Model: a full-length frame started while armed commits 4 clocks after CS rises;
    // 2^TW-1 clocks without a commit releases everything.
    always @(negedge CLK_14MHZ) begin
        if (!CPU_RESET) begin
            m_mat = '1; m_joy = 8'h00; m_link = 1'b0; m_fok = 1'b0;
            age = 0; pend = 1'b0; cs_high_seen = 1'b0; arm_ok = 1'b0;
        end else if (pend && cyc == pend_cyc) begin
            m_mat = pend_bits[39:0];
            for (int k = 0; k < 8; k++) m_joy[7-k] = JOY_EN ? pend_bits[40+k] : 1'b0;
            m_link = 1'b1; m_fok = 1'b1; age = 0; pend = 1'b0;
        end else begin
            m_fok = 1'b0;
            if (age < WD) age++;
            if (age == WD) begin
                m_mat = '1; m_joy = 8'h00; m_link = 1'b0;
            end
        end
        kd_e = '1;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 5; c++)
                if (!A_HI[r] && !m_mat[r*5+c]) kd_e[c] = 1'b0;
        check("kd", {3'b000, kd}, {3'b000, kd_e});
        check("joy", joy, m_joy);
        check("link_up", {7'd0, link_up}, {7'd0, m_link});
        check("frame_ok", {7'd0, frame_ok}, {7'd0, m_fok});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK_14MHZ);
            #1;
        end
    endtask

    function automatic logic [47:0] mk(input logic [39:0] keys, input logic [7:0] j);
        logic [47:0] f;
        f[39:0] = keys;
        for (int k = 0; k < 8; k++) f[40+k] = j[7-k];
        return f;
    endfunction

    task automatic send_bit(input logic b);
        KBD_DI = b;
        if (nbits < 48) rx[nbits] = b;
        tick(2);
        KBD_CLK = 1'b1;
        tick(3);
        KBD_CLK = 1'b0;
        tick(2);
        nbits++;
    endtask

    task automatic cs_fall();
        KBD_CS = 1'b0;
        arm_ok = cs_high_seen;
        nbits  = 0;
        tick(4);
    endtask

    // CS fall and the first clock rise land on the same synced cycle
    task automatic cs_fall_clk(input logic b);
        KBD_DI = b;
        tick(2);
        KBD_CS  = 1'b0;
        KBD_CLK = 1'b1;
        arm_ok  = cs_high_seen;
        rx[0]   = b;
        nbits   = 1;
        tick(3);
        KBD_CLK = 1'b0;
        tick(2);
    endtask

    task automatic cs_rise(input bit probe);
        KBD_CS = 1'b1;
        if (arm_ok && nbits == FB) begin
            pend_bits = rx;
            pend_cyc  = cyc + 4;
            pend      = 1'b1;
        end
        if (probe) begin
            tick(3);
            check("fok_before_4clk", {7'd0, frame_ok}, 8'h00);
            tick(1);
            check("fok_at_4clk", {7'd0, frame_ok}, 8'h01);
            tick(2);
        end else begin
            tick(6);
        end
        cs_high_seen = 1'b1;
    endtask

    task automatic send_frame(input logic [47:0] f, input int n, input bit probe);
        cs_fall();
        for (int i = 0; i < n; i++) send_bit(i < 48 ? f[i] : 1'b1);
        cs_rise(probe);
    endtask

    task automatic probe_kd(input string name, input logic [7:0] a, input logic [4:0] exp);
        A_HI = a;
        #1;
        check(name, {3'b000, kd}, {3'b000, exp});
    endtask

    initial begin
        CPU_RESET = 1'b0; KBD_CLK = 1'b0; KBD_DI = 1'b1; KBD_CS = 1'b0; A_HI = 8'h00;
        tick(4);
        CPU_RESET = 1'b1;
        tick(2);
        check("rst_kd", {3'b000, kd}, 8'h1f);
        check("rst_joy", joy, 8'h00);
        check("rst_link", {7'd0, link_up}, 8'h00);

        // full-length burst with CS never seen high: receiver stays disarmed
        nbits = 0;
        for (int i = 0; i < FB; i++) send_bit(1'b0);
        cs_rise(1'b0);
        check("unarmed_link", {7'd0, link_up}, 8'h00);
        probe_kd("unarmed_kd", 8'h00, 5'b11111);

        // single key: CAPS SHIFT plus FIRE
        send_frame(mk(40'hFF_FFFF_FFFE, 8'h10), FB, 1'b1);
        probe_kd("single_fe", 8'hFE, 5'b11110);
        probe_kd("single_fd", 8'hFD, 5'b11111);
        check("single_joy", joy, JOY_EN ? 8'h10 : 8'h00);
        check("single_link", {7'd0, link_up}, 8'h01);

        // two rows ANDed: row 1 col 2 and row 6 col 4
        mat = '1; mat[7] = 1'b0; mat[34] = 1'b0;
        send_frame(mk(mat, 8'h81), FB, 1'b0);
        probe_kd("multi_bd", 8'hBD, 5'b01011);
        probe_kd("multi_ff", 8'hFF, 5'b11111);
        check("multi_joy", joy, JOY_EN ? 8'h81 : 8'h00);

        // silence: keys held until 255 clocks after the commit, then released
        tick(200);
        check("wd_hold_link", {7'd0, link_up}, 8'h01);
        probe_kd("wd_hold_kd", 8'hBD, 5'b01011);
        for (int i = 0; i < 60; i++) begin
            A_HI = 8'($urandom_range(0, 255));
            tick(1);
        end
        check("wd_expired_link", {7'd0, link_up}, 8'h00);
        probe_kd("wd_expired_kd", 8'hBD, 5'b11111);
        check("wd_expired_joy", joy, 8'h00);

        // wrong lengths (short, long, saturated) never commit their all-pressed payload
        send_frame(mk(40'h0, 8'hFF), FB - 1, 1'b0);
        check("short_link", {7'd0, link_up}, 8'h00);
        probe_kd("short_kd", 8'h00, 5'b11111);
        send_frame(mk(40'h0, 8'hFF), FB + 1, 1'b0);
        check("long_link", {7'd0, link_up}, 8'h00);
        probe_kd("long_kd", 8'h00, 5'b11111);
        send_frame(mk(40'h0, 8'hFF), 70, 1'b0);
        check("sat_joy", joy, 8'h00);
        probe_kd("sat_kd", 8'h00, 5'b11111);
        mat = '1; mat[12] = 1'b0;
        send_frame(mk(mat, 8'h02), FB, 1'b0);
        probe_kd("after_bad_fb", 8'hFB, 5'b11011);
        check("after_bad_joy", joy, JOY_EN ? 8'h02 : 8'h00);

        // CS fall coincident with the first clock rise: that bit is bit 0
        mat = '1; mat[0] = 1'b0; mat[39] = 1'b0;
        rx = mk(mat, 8'h40);
        cs_fall_clk(rx[0]);
        begin
            logic [47:0] f;
            f = mk(mat, 8'h40);
            for (int i = 1; i < FB; i++) send_bit(f[i]);
        end
        cs_rise(1'b0);
        probe_kd("coinc_fe", 8'hFE, 5'b11110);
        probe_kd("coinc_7f", 8'h7F, 5'b01111);
        probe_kd("coinc_7e", 8'h7E, 5'b01110);

        // reset after 20 bits, release with CS still low: the tail must not commit
        begin
            logic [47:0] f;
            f = mk(40'h0, 8'hFF);
            cs_fall();
            for (int i = 0; i < 20; i++) send_bit(f[i]);
            CPU_RESET = 1'b0;
            tick(3);
            CPU_RESET = 1'b1;
            for (int i = 20; i < FB; i++) send_bit(f[i]);
            cs_rise(1'b0);
        end
        check("rstmid_link", {7'd0, link_up}, 8'h00);
        probe_kd("rstmid_kd", 8'h00, 5'b11111);
        mat = '1; mat[5] = 1'b0;
        send_frame(mk(mat, 8'h04), FB, 1'b0);
        probe_kd("rstmid_next_fd", 8'hFD, 5'b11110);
        check("rstmid_next_link", {7'd0, link_up}, 8'h01);
        check("rstmid_next_joy", joy, JOY_EN ? 8'h04 : 8'h00);

        tick(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/zx_kbd_spi_rx.md
# zx_kbd_spi_rx

SPI keyboard/joystick receiver feeding the port #FE key-data field and the port #1F joystick read path. It takes serial frames from the USB/PS2/SEGA controller on KBD_CLK/KBD_DI/KBD_CS and holds a 40-key ZX matrix plus a Kempston byte. It answers half-row scans from CPU A[15:8] with the 5-bit active-low key column value. A link watchdog releases all keys when the controller goes silent.

## Interface
- TIMEOUT_W, 22: width of the link watchdog counter; the timeout is 2^TIMEOUT_W − 1 clocks (≈0.3 s at 14 MHz).
- CLK_14MHZ  in  1  system clock.
- CPU_RESET  in  1  reset, asynchronous, active-low; clock CLK_14MHZ.
- KBD_CLK  in  1  SPI clock from the controller. Asynchronous. Data is sampled on the rising edge.
- KBD_DI  in  1  SPI data. Asynchronous.
- KBD_CS  in  1  SPI frame select, active-low. Asynchronous.
- A_HI  in  8  CPU A[15:8]. A 0 bit selects the corresponding half-row.
- kd  out  5  key columns for port #FE bits [4:0]. Active-low; 1 = not pressed.
- joy  out  8  Kempston byte for the port #1F read. Active-high.
- frame_ok  out  1  one-clock pulse when a valid frame is committed.
- link_up  out  1  high after the first valid frame; low after a watchdog timeout.

## Operation
- **Synchronizers**
  - KBD_CLK, KBD_DI and KBD_CS each pass through a 2-flop synchronizer.
  - A third flop on KBD_CLK and KBD_CS provides edge detection.
- **Arming**
  - The receiver is disarmed after reset.
  - It arms on the first sampled cycle in which synced CS = 1.
  - While disarmed, clock edges and CS edges are ignored. This prevents half-frames that straddle reset from being committed.
- **Frame start**
  - A synced CS falling edge clears the 6-bit bit counter.
- **Shifting**
  - Each synced KBD_CLK rising edge while CS = 0 shifts KBD_DI into a shift register.
  - The bit counter increments and saturates at 63.
- **Bit order** (arrival index n, starting at 0)
  - For n < 40: row = n/5 (row 0 ↔ A8 … row 7 ↔ A15), column = n mod 5. 0 = pressed.
  - For n = 40..47: joy[7−(n−40)], i.e. MSB first.
- **Commit**
  - On a synced CS rising edge with count == FRAME_BITS, the shift register is copied to the matrix and joy registers.
  - frame_ok pulses, link_up is set, and the watchdog is cleared.
  - Any other count (short, long or saturated) discards the frame silently. Registers are unchanged and there is no pulse.
- **Column output**
  - kd[c] = AND over rows r with A_HI[r] = 0 of matrix[r][c].
  - kd is purely combinational from the matrix register and A_HI.
  - A_HI = 8'hFF gives kd = 5'b11111.
- **Watchdog**
  - A TIMEOUT_W-bit counter increments every clock and saturates at all-ones.
  - On reaching all-ones it sets the matrix to all 1s, sets joy to 0 and clears link_up.
  - It then holds until the next commit.
- **Reset values**
  - Matrix all 1s (kd = 5'b11111), joy = 8'h00.
  - frame_ok = 0, link_up = 0.
  - Counters 0, disarmed.

## Timing
- The synced KBD_CLK high and low phases must each be ≥ 3 CLK_14MHZ periods, i.e. KBD_CLK ≤ 2 MHz.
- KBD_DI must be stable for 3 clocks around the KBD_CLK rise.
- Latency from KBD_CS rising at the pin to the matrix/joy update and frame_ok is 4 clocks.
- kd follows A_HI in the same cycle, with no register.
- Simultaneous events:
  - A KBD_CLK rise detected in the same cycle as a CS rise is not shifted.
  - A commit in the same cycle as a watchdog expiry: the commit wins.
  - A CS fall in the same cycle as a CLK rise: the counter clears, and the bit is shifted as bit 0.
- Reset asserted mid-frame clears everything immediately. No partial data is ever committed.

## Configuration
- KBD_JOY_EN defined:
  - FRAME_BITS = 48 and the joystick byte is received as above.
- KBD_JOY_EN undefined:
  - FRAME_BITS = 40, no joystick shift stage exists, and joy is tied to 8'h00.
  - A 48-bit frame is then discarded as too long.

## Test plan
- **Reset defaults:** after reset, A_HI = 8'h00 → kd = 5'b11111, joy = 8'h00, link_up = 0. A KBD_CLK burst with no CS high seen first → no frame_ok.
- **Single key:** a 48-bit frame with bit 0 = 0 (CAPS SHIFT, row 0 col 0), all other matrix bits 1, joy = 8'h10 (FIRE).
  - Expect frame_ok 4 clocks after the CS rise.
  - A_HI = 8'hFE → kd = 5'b11110; A_HI = 8'hFD → kd = 5'b11111; joy = 8'h10; link_up = 1.
- **Multi-row AND:** keys at row 1 col 2 and row 6 col 4 pressed.
  - A_HI = 8'hBD → kd = 5'b01011; A_HI = 8'hFF → kd = 5'b11111.
- **Bad length:** a 47-bit frame or a 49-bit frame → no frame_ok and the previous matrix/joy are unchanged. A following 48-bit frame commits normally.
- **Watchdog:** with TIMEOUT_W = 8, a valid frame with keys pressed is followed by silence. After 255 clocks, kd = 5'b11111, joy = 0 and link_up = 0.
- **Reset mid-frame:** assert CPU_RESET after 20 bits, then release while CS is still low and finish the frame → no commit. The next full frame commits.
